// File: rtl/ram_loader_pkg.sv
// Shared definitions for the program-RAM loader: FSM state encoding, error codes
// and the length-byte decode used by the loader and the host-side test driver.
package ram_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_DATA,
      ST_SUM,
      ST_VERIFY,
      ST_DONE,
      ST_ERROR
   } state_t;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_SUM      = 2'd1;
   localparam logic [1:0] ERR_READBACK = 2'd2;
   localparam logic [1:0] ERR_ABORT    = 2'd3;

   localparam int IDX_W = 9;

   // A length byte of zero means a full 256-word image.
   function automatic logic [IDX_W-1:0] len_to_count(input logic [7:0] len);
      return (len == 8'd0) ? 9'd256 : {1'b0, len};
   endfunction

endpackage

// File: rtl/ram_loader.sv
// Host-side program-RAM writer: receives length/payload/checksum, writes the payload,
// then re-reads the region and sums it to verify the image before releasing the CPU.
//
// state     | meaning
// ST_IDLE   | after reset or abort; waits for start
// ST_LEN    | takes the length byte
// ST_DATA   | takes payload bytes, one RAM write per accepted byte
// ST_SUM    | takes the checksum byte and compares it to the running sum
// ST_VERIFY | reads back N words, summing r_data
// ST_DONE   | image verified, CPU released
// ST_ERROR  | checksum or readback mismatch, CPU stays held
module ram_loader
   import ram_loader_pkg::*;
#(
   parameter int                ADDR_W    = 8,
   parameter int                DATA_W    = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic              rx_valid,
   input  logic [DATA_W-1:0] rx_data,
   output logic              rx_ready,
   output logic              write_req,
   output logic [ADDR_W-1:0] w_addr,
   output logic [DATA_W-1:0] w_data,
   output logic [ADDR_W-1:0] r_addr,
   input  logic [DATA_W-1:0] r_data,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic [1:0]        err_code
);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] sum_q, sum_d;
   logic [DATA_W-1:0] rb_q, rb_d;
   logic              rx_ready_q, rx_ready_d;
   logic              write_req_q, write_req_d;
   logic [ADDR_W-1:0] w_addr_q, w_addr_d;
   logic [DATA_W-1:0] w_data_q, w_data_d;
   logic [ADDR_W-1:0] r_addr_q, r_addr_d;
   logic              cpu_hold_q, cpu_hold_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [1:0]        err_q, err_d;

   logic              accept;
   logic              active;
   logic              last;
   logic [IDX_W-1:0]  idx_inc;
   logic [DATA_W-1:0] rb_next;

   assign accept  = rx_valid & rx_ready_q;
   assign active  = (state_q == ST_LEN) || (state_q == ST_DATA) ||
                    (state_q == ST_SUM) || (state_q == ST_VERIFY);
   assign idx_inc = idx_q + 9'd1;
   assign last    = (idx_q == cnt_q - 9'd1);
   assign rb_next = rb_q + r_data;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      sum_d       = sum_q;
      rb_d        = rb_q;
      rx_ready_d  = rx_ready_q;
      write_req_d = 1'b0;
      w_addr_d    = w_addr_q;
      w_data_d    = w_data_q;
      r_addr_d    = r_addr_q;
      cpu_hold_d  = cpu_hold_q;
      busy_d      = busy_q;
      done_d      = done_q;
      err_d       = err_q;

      // abort outranks both start and any byte transfer in the same cycle
      if (active && abort) begin
         state_d    = ST_IDLE;
         err_d      = ERR_ABORT;
         rx_ready_d = 1'b0;
         cpu_hold_d = 1'b0;
         busy_d     = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (start) begin
                  state_d    = ST_LEN;
                  done_d     = 1'b0;
                  err_d      = ERR_NONE;
                  cpu_hold_d = 1'b1;
                  rx_ready_d = 1'b1;
                  busy_d     = 1'b1;
               end
            end
            ST_LEN: begin
               if (accept) begin
                  cnt_d   = len_to_count(rx_data);
                  idx_d   = '0;
                  sum_d   = '0;
                  state_d = ST_DATA;
               end
            end
            ST_DATA: begin
               if (accept) begin
                  write_req_d = 1'b1;
                  w_addr_d    = BASE_ADDR + ADDR_W'(idx_q);
                  w_data_d    = rx_data;
                  sum_d       = sum_q + rx_data;
                  idx_d       = idx_inc;
                  if (last) state_d = ST_SUM;
               end
            end
            ST_SUM: begin
               if (accept) begin
                  rx_ready_d = 1'b0;
                  if (rx_data != sum_q) begin
                     state_d = ST_ERROR;
                     err_d   = ERR_SUM;
                     busy_d  = 1'b0;
                  end else begin
                     idx_d    = '0;
                     rb_d     = '0;
                     r_addr_d = BASE_ADDR;
                     state_d  = ST_VERIFY;
                  end
               end
            end
            ST_VERIFY: begin
               // r_addr_q already points at BASE_ADDR+idx_q for this cycle's read
               rb_d     = rb_next;
               idx_d    = idx_inc;
               r_addr_d = BASE_ADDR + ADDR_W'(idx_inc);
               if (last) begin
                  busy_d = 1'b0;
                  if (rb_next == sum_q) begin
                     state_d    = ST_DONE;
                     done_d     = 1'b1;
                     cpu_hold_d = 1'b0;
                  end else begin
                     state_d = ST_ERROR;
                     err_d   = ERR_READBACK;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         sum_q       <= '0;
         rb_q        <= '0;
         rx_ready_q  <= 1'b0;
         write_req_q <= 1'b0;
         w_addr_q    <= '0;
         w_data_q    <= '0;
         r_addr_q    <= '0;
         cpu_hold_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= ERR_NONE;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         sum_q       <= sum_d;
         rb_q        <= rb_d;
         rx_ready_q  <= rx_ready_d;
         write_req_q <= write_req_d;
         w_addr_q    <= w_addr_d;
         w_data_q    <= w_data_d;
         r_addr_q    <= r_addr_d;
         cpu_hold_q  <= cpu_hold_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign rx_ready  = rx_ready_q;
   assign write_req = write_req_q;
   assign w_addr    = w_addr_q;
   assign w_data    = w_data_q;
   assign r_addr    = r_addr_q;
   assign cpu_hold  = cpu_hold_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err_code  = err_q;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: two instances (base 00 and FE) driven in lockstep, each with
// its own RAM model; table-driven sessions, hand corner cases, then random sessions.
module tb_ram_loader;
   import ram_loader_pkg::*;

   logic clk = 1'b0;
   logic reset, start, abort, rx_valid;
   logic [7:0] rx_data;
   logic [1:0] rx_ready, write_req, cpu_hold, busy, done;
   logic [1:0][7:0] w_addr, w_data, r_addr, r_data;
   logic [1:0][1:0] err_code;
   logic corrupt_en;
   logic [7:0] corrupt_off;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam logic [7:0] BASE = (g == 0) ? 8'h00 : 8'hFE;
      logic [7:0] mem [256];
      ram_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(BASE)) dut (
         .clk(clk), .reset(reset), .start(start), .abort(abort),
         .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready[g]),
         .write_req(write_req[g]), .w_addr(w_addr[g]), .w_data(w_data[g]),
         .r_addr(r_addr[g]), .r_data(r_data[g]), .cpu_hold(cpu_hold[g]),
         .busy(busy[g]), .done(done[g]), .err_code(err_code[g]));
      always @(posedge clk) if (write_req[g]) mem[w_addr[g]] <= w_data[g];
      // a corrupted location reads back with bit 0 flipped
      assign r_data[g] = mem[r_addr[g]] ^
                         ((corrupt_en && r_addr[g] == 8'(BASE + corrupt_off)) ? 8'h01 : 8'h00);
   end

   function automatic logic [7:0] base_of(input int g);
      return (g == 0) ? 8'h00 : 8'hFE;
   endfunction

   function automatic logic [7:0] mem_at(input int g, input logic [7:0] a);
      return (g == 0) ? g_dut[0].mem[a] : g_dut[1].mem[a];
   endfunction

   function automatic void chk(input string name, input int g, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s dut%0d: got 0x%0h, want 0x%0h", name, g, act, exp);
      end
   endfunction

   function automatic void chk1(input string name, input logic [1:0] v, input logic exp);
      for (int g = 0; g < 2; g++) chk(name, g, int'(v[g]), int'(exp));
   endfunction

   function automatic void chk_reset(input string name);
      chk1({name, ".rx_ready"}, rx_ready, 1'b0);
      chk1({name, ".write_req"}, write_req, 1'b0);
      chk1({name, ".cpu_hold"}, cpu_hold, 1'b0);
      chk1({name, ".busy"}, busy, 1'b0);
      chk1({name, ".done"}, done, 1'b0);
      for (int g = 0; g < 2; g++) begin
         chk({name, ".w_addr"}, g, int'(w_addr[g]), 0);
         chk({name, ".w_data"}, g, int'(w_data[g]), 0);
         chk({name, ".r_addr"}, g, int'(r_addr[g]), 0);
         chk({name, ".err_code"}, g, int'(err_code[g]), 0);
      end
   endfunction

   // all tasks start and end just after a falling edge
   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk1("start.busy", busy, 1'b1);
      chk1("start.cpu_hold", cpu_hold, 1'b1);
      chk1("start.done", done, 1'b0);
      chk1("start.rx_ready", rx_ready, 1'b1);
      for (int g = 0; g < 2; g++) chk("start.err_code", g, int'(err_code[g]), int'(ERR_NONE));
   endtask

   task automatic send_byte(input logic [7:0] b, input bit is_data, input int idx);
      rx_valid = 1'b1;
      rx_data  = b;
      chk1("rx_ready", rx_ready, 1'b1);
      @(negedge clk);
      rx_valid = 1'b0;
      if (is_data) begin
         chk1("data.write_req", write_req, 1'b1);
         for (int g = 0; g < 2; g++) begin
            chk("data.w_addr", g, int'(w_addr[g]), int'(8'(base_of(g) + idx)));
            chk("data.w_data", g, int'(w_data[g]), int'(b));
         end
      end else begin
         chk1("ctl.write_req", write_req, 1'b0);
      end
   endtask

   task automatic run_session(input int n, input logic [7:0] pl[$], input bit lit,
                              input logic [7:0] lit_sum, input bit corrupt, input int coff,
                              input int gap_pct, input int glitch, input logic [1:0] exp_err,
                              input bit exp_done, input bit exp_hold);
      logic [7:0] sum;
      logic [7:0] ck;
      int cyc;
      int miss;
      sum = 8'h00;
      foreach (pl[i]) sum = sum + pl[i];
      ck = lit ? lit_sum : sum;
      corrupt_en  = corrupt;
      corrupt_off = 8'(coff);
      do_start();
      send_byte(8'(n), 1'b0, 0);
      for (int i = 0; i < n; i++) begin
         if (i == glitch) start = 1'b1;
         send_byte(pl[i], 1'b1, i);
         start = 1'b0;
         if (int'($urandom_range(99)) < gap_pct) begin
            @(negedge clk);
            chk1("gap.write_req", write_req, 1'b0);
         end
      end
      send_byte(ck, 1'b0, 0);
      if (exp_err != ERR_SUM) begin
         chk1("verify.rx_ready", rx_ready, 1'b0);
         chk1("verify.busy", busy, 1'b1);
         cyc = 0;
         while (busy[0] && cyc < n + 8) begin
            @(negedge clk);
            cyc++;
         end
         chk("verify.cycles", 0, cyc, n);
      end
      chk1("end.busy", busy, 1'b0);
      chk1("end.done", done, exp_done);
      chk1("end.cpu_hold", cpu_hold, exp_hold);
      chk1("end.rx_ready", rx_ready, 1'b0);
      for (int g = 0; g < 2; g++) begin
         chk("end.err_code", g, int'(err_code[g]), int'(exp_err));
         miss = 0;
         for (int i = 0; i < n; i++)
            if (mem_at(g, 8'(base_of(g) + i)) !== pl[i]) miss++;
         chk("end.mem_image", g, miss, 0);
      end
      corrupt_en = 1'b0;
   endtask

   typedef struct {
      int         n;
      bit         ramp;
      logic [31:0] head;
      logic [7:0] b0;
      logic [7:0] step;
      bit         lit;
      logic [7:0] lit_sum;
      bit         corrupt;
      int         coff;
      int         gap_pct;
      logic [1:0] exp_err;
      bit         exp_done;
      bit         exp_hold;
   } vec_t;

   vec_t vecs[9];
   logic [7:0] pl[$];
   int n, glitch, coff;
   bit bad_s, cor;
   logic [7:0] s;
   logic [1:0] e;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // 60+80+A0+90 = 0x210, so the matching checksum byte is 10
      vecs[0] = '{4,   1'b0, 32'h6080A090, 8'h00, 8'h00, 1'b1, 8'h10, 1'b0, 0, 0,  ERR_NONE,     1'b1, 1'b0};
      vecs[1] = '{4,   1'b0, 32'h6080A090, 8'h00, 8'h00, 1'b1, 8'h91, 1'b0, 0, 0,  ERR_SUM,      1'b0, 1'b1};
      vecs[2] = '{4,   1'b0, 32'h6080A090, 8'h00, 8'h00, 1'b1, 8'h10, 1'b1, 2, 0,  ERR_READBACK, 1'b0, 1'b1};
      // 0+1+..+255 = 0x7F80
      vecs[3] = '{256, 1'b1, 32'h0,        8'h00, 8'h01, 1'b1, 8'h80, 1'b0, 0, 0,  ERR_NONE,     1'b1, 1'b0};
      vecs[4] = '{6,   1'b1, 32'h0,        8'h11, 8'h23, 1'b0, 8'h00, 1'b0, 0, 50, ERR_NONE,     1'b1, 1'b0};
      vecs[5] = '{1,   1'b1, 32'h0,        8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 0, 0,  ERR_NONE,     1'b1, 1'b0};
      vecs[6] = '{3,   1'b1, 32'h0,        8'h05, 8'h07, 1'b0, 8'h00, 1'b1, 0, 0,  ERR_READBACK, 1'b0, 1'b1};
      vecs[7] = '{5,   1'b1, 32'h0,        8'h40, 8'h10, 1'b0, 8'h00, 1'b1, 4, 30, ERR_READBACK, 1'b0, 1'b1};
      vecs[8] = '{2,   1'b1, 32'h0,        8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 0, 0,  ERR_SUM,      1'b0, 1'b1};

      reset = 1'b1; start = 1'b0; abort = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      corrupt_en = 1'b0; corrupt_off = 8'h00;
      @(negedge clk);
      chk_reset("reset");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk_reset("idle");

      foreach (vecs[k]) begin
         pl.delete();
         for (int i = 0; i < vecs[k].n; i++)
            pl.push_back(vecs[k].ramp ? 8'(vecs[k].b0 + vecs[k].step * i)
                                      : vecs[k].head[31 - 8*i -: 8]);
         run_session(vecs[k].n, pl, vecs[k].lit, vecs[k].lit_sum, vecs[k].corrupt, vecs[k].coff,
                     vecs[k].gap_pct, -1, vecs[k].exp_err, vecs[k].exp_done, vecs[k].exp_hold);
      end

      // abort after the second data byte, with a byte offered in the same cycle
      do_start();
      send_byte(8'h04, 1'b0, 0);
      send_byte(8'h21, 1'b1, 0);
      send_byte(8'h43, 1'b1, 1);
      abort = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
      @(negedge clk);
      abort = 1'b0; rx_valid = 1'b0;
      chk1("abort.busy", busy, 1'b0);
      chk1("abort.cpu_hold", cpu_hold, 1'b0);
      chk1("abort.write_req", write_req, 1'b0);
      chk1("abort.rx_ready", rx_ready, 1'b0);
      chk1("abort.done", done, 1'b0);
      for (int g = 0; g < 2; g++) chk("abort.err_code", g, int'(err_code[g]), int'(ERR_ABORT));

      // start and abort together while busy
      do_start();
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk1("start_abort.busy", busy, 1'b0);
      for (int g = 0; g < 2; g++) chk("start_abort.err_code", g, int'(err_code[g]), int'(ERR_ABORT));

      // asynchronous reset in the middle of DATA, checked before the next rising edge
      do_start();
      send_byte(8'h03, 1'b0, 0);
      send_byte(8'hA5, 1'b1, 0);
      send_byte(8'h3C, 1'b1, 1);
      #2 reset = 1'b1;
      #1 chk_reset("async_reset");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk_reset("after_reset");

      for (int r = 0; r < 24; r++) begin
         n = int'($urandom_range(1, 24));
         pl.delete();
         s = 8'h00;
         for (int i = 0; i < n; i++) begin
            pl.push_back(8'($urandom));
            s = s + pl[i];
         end
         bad_s  = ($urandom_range(3) == 0);
         cor    = !bad_s && ($urandom_range(3) == 0);
         coff   = int'($urandom_range(0, n - 1));
         glitch = ($urandom_range(2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
         e      = bad_s ? ERR_SUM : (cor ? ERR_READBACK : ERR_NONE);
         run_session(n, pl, bad_s, s ^ 8'($urandom_range(1, 255)), cor, coff,
                     int'($urandom_range(0, 60)), glitch, e, e == ERR_NONE, e != ERR_NONE);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
